alu_74181: RTL and testbench
============================

# alu_74181

Registered 4-bit ALU implementing the full 74181 function set: 16 logic and 16 arithmetic functions, selected by `s` and `M`, with active-low carry-in/out and group propagate/generate for look-ahead. All outputs are captured in flops once per clock. It is the datapath core of the accumulator: `Y` feeds back into operand `b`, so with `s=1001`, `M=0`, `a=1` it advances by `a` every clock.

## Interface
- No parameters; width fixed at 4 bits.
- `clk  input  1`  single clock; all state updates on rising edge.
- `reset  input  1`  synchronous, active-high; clears all output registers.
- `a  input  4`  operand A.
- `b  input  4`  operand B.
- `s  input  4`  function select S3..S0.
- `M  input  1`  mode: 1 = logic, 0 = arithmetic.
- `Ci_inverse  input  1`  active-low carry-in (0 = add one).
- `Y  output  4`  registered function result F.
- `Co_inverse  output  1`  registered active-low carry-out (0 = carry out of bit 3).
- `P  output  1`  registered active-low group propagate.
- `Q  output  1`  registered active-low group generate.
- `AequalsB  output  1`  registered; 1 when `Y` is all ones.

## Operation
- Per-bit terms, bits 0..3:
  - `G = a | (b & S0) | (~b & S1)`
  - `H = (a & b & S3) | (a & ~b & S2)`
- Carry-in `cin = ~Ci_inverse`.
- Arithmetic (`M=0`): `F = (G + H + cin) mod 16`; `cout` = bit 4 of that 5-bit sum. Resulting function table, without cin:
  - 0000 A; 0001 A|B; 0010 A|~B; 0011 minus 1 (1111)
  - 0100 A plus (A&~B); 0101 (A|B) plus (A&~B); 0110 A minus B minus 1; 0111 (A&~B) minus 1
  - 1000 A plus (A&B); 1001 A plus B; 1010 (A|~B) plus (A&B); 1011 (A&B) minus 1
  - 1100 A plus A; 1101 (A|B) plus A; 1110 (A|~B) plus A; 1111 A minus 1
  - With `Ci_inverse=0`, each arithmetic result is incremented by 1.
- Logic (`M=1`): `F = ~(G ^ H)` per bit; `cin` is ignored for F. Resulting function table:
  - 0000 ~A; 0001 ~(A|B); 0010 ~A&B; 0011 0
  - 0100 ~(A&B); 0101 ~B; 0110 A^B; 0111 A&~B
  - 1000 ~A|B; 1001 ~(A^B); 1010 B; 1011 A&B
  - 1100 1111; 1101 A|~B; 1110 A|B; 1111 A
- `Co_inverse = ~cout` in both modes. It is always computed from the arithmetic sum, even in logic mode.
- `P = ~(G3 & G2 & G1 & G0)`.
- `Q = ~(H3 | G3&H2 | G3&G2&H1 | G3&G2&G1&H0)`. Independent of `cin` and `M`.
- `AequalsB = &F`. In arithmetic mode 0110 with `Ci_inverse=1`, this is true exactly when a == b.
- No internal state besides the output registers.

## Timing
- One-cycle latency: inputs sampled at rising edge N appear on all outputs after edge N and hold until edge N+1.
- Reset: when `reset=1` at a rising edge, outputs become `Y=0000`, `Co_inverse=1`, `P=1`, `Q=1`, `AequalsB=0`. Reset takes priority over inputs that cycle.
- Reset mid-operation discards the in-flight result. The first post-reset result appears one edge after `reset` is deasserted.
- Asynchronous changes of `reset` between edges have no effect.
- Wrap-around: arithmetic overflow wraps mod 16 and is signalled only by `Co_inverse=0`. There is no sticky overflow flag.
- Feedback use (`Y` to `b`) is legal. Each clock performs exactly one operation on the previous registered value.

## Test plan
- Reset: assert `reset` one edge with random inputs -> `Y=0`, `Co_inverse=1`, `P=1`, `Q=1`, `AequalsB=0`.
- Accumulate: `a=1`, `b<=Y`, `s=1001`, `M=0`, `Ci_inverse=1` after reset.
  - `Y` runs 1,2,…,15,0 on successive edges.
  - `AequalsB=1` only while `Y=15`.
  - `Co_inverse=0` on the edge producing 0.
- Add/compare:
  - `a=9`, `b=9`, `s=0110`, `M=0`, `Ci_inverse=1` -> `Y=1111`, `AequalsB=1`, `Co_inverse=1`.
  - Same with `Ci_inverse=0` -> `Y=0000`, `Co_inverse=0`.
- Add with carry: `a=7`, `b=9`, `s=1001`, `M=0`, `Ci_inverse=1` -> `Y=0000`, `Co_inverse=0`, `P=0`, `Q=0`.
- Logic sweep: `a=1100`, `b=1010`, `M=1`, all 16 `s` -> for example:
  - `s=0110` gives 0110; `s=1011` gives 1000; `s=1110` gives 1110; `s=0011` gives 0000.
  - All 16 results must match the logic function table.
- Exhaustive: all a, b, s, M, Ci_inverse combinations versus a G/H reference model, compared one cycle later.

Source files
------------

// File: rtl/alu_74181_if.sv
// Operand, control and result bundle for the registered 74181 ALU.
interface alu_74181_if;
   logic [3:0] a;
   logic [3:0] b;
   logic [3:0] s;
   logic       M;
   logic       Ci_inverse;
   logic [3:0] Y;
   logic       Co_inverse;
   logic       P;
   logic       Q;
   logic       AequalsB;

   modport master (
      output a, b, s, M, Ci_inverse,
      input  Y, Co_inverse, P, Q, AequalsB
   );

   modport slave (
      input  a, b, s, M, Ci_inverse,
      output Y, Co_inverse, P, Q, AequalsB
   );
endinterface

// File: rtl/alu_74181.sv
// Registered 4-bit 74181 ALU: 16 logic and 16 arithmetic functions,
// active-low carry in/out, active-low group propagate/generate.
module alu_74181 (
   input  logic        clk,
   input  logic        reset,
   alu_74181_if.slave  bus
);

   logic [3:0] g;
   logic [3:0] h;
   logic [4:0] sum;
   logic [3:0] f;
   logic       p_n;
   logic       q_n;

   // Per-bit G/H terms, arithmetic sum and look-ahead outputs.
   always_comb begin
      g   = bus.a | (bus.b & {4{bus.s[0]}}) | (~bus.b & {4{bus.s[1]}});
      h   = (bus.a & bus.b & {4{bus.s[3]}}) | (bus.a & ~bus.b & {4{bus.s[2]}});
      sum = {1'b0, g} + {1'b0, h} + {4'b0000, ~bus.Ci_inverse};
      f   = bus.M ? ~(g ^ h) : sum[3:0];
      p_n = ~(&g);
      q_n = ~(h[3] | (g[3] & h[2]) | (g[3] & g[2] & h[1]) |
               (g[3] & g[2] & g[1] & h[0]));
   end

   // Output registers; reset has priority over the computed result.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.Y          <= '0;
         bus.Co_inverse <= 1'b1;
         bus.P          <= 1'b1;
         bus.Q          <= 1'b1;
         bus.AequalsB   <= 1'b0;
      end else begin
         bus.Y          <= f;
         bus.Co_inverse <= ~sum[4];
         bus.P          <= p_n;
         bus.Q          <= q_n;
         bus.AequalsB   <= &f;
      end
   end

endmodule

// File: tb/tb_alu_74181.sv
// Scoreboard bench for alu_74181: stimulus pushes expected results built
// from the function tables; a monitor pops and compares after each edge.
module tb_alu_74181;

   logic clk;
   logic reset;
   alu_74181_if bus();

   alu_74181 dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {Y, Co_inverse, P, Q, AequalsB}
   logic [7:0] exp_q[$];
   string      tag_q[$];
   int         total = 0;
   int         bad   = 0;

   localparam logic [7:0] RESET_EXP = {4'b0000, 1'b1, 1'b1, 1'b1, 1'b0};

   // Reference: two-operand form of each arithmetic function, then the
   // logic function table, then look-ahead flags.
   function automatic logic [7:0] model(input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] s, input logic m,
                                        input logic ci_n);
      int t1, t2, ia, ib, inb, sum, nocin;
      logic [3:0] lf, y, gbit;
      logic cout, p, q;
      ia  = int'(a);
      ib  = int'(b);
      inb = 15 - ib;
      case (s)
         4'h0: begin t1 = ia;         t2 = 0;          end
         4'h1: begin t1 = ia | ib;    t2 = 0;          end
         4'h2: begin t1 = ia | inb;   t2 = 0;          end
         4'h3: begin t1 = 15;         t2 = 0;          end
         4'h4: begin t1 = ia;         t2 = ia & inb;   end
         4'h5: begin t1 = ia | ib;    t2 = ia & inb;   end
         4'h6: begin t1 = ia;         t2 = inb;        end
         4'h7: begin t1 = ia & inb;   t2 = 15;         end
         4'h8: begin t1 = ia;         t2 = ia & ib;    end
         4'h9: begin t1 = ia;         t2 = ib;         end
         4'hA: begin t1 = ia | inb;   t2 = ia & ib;    end
         4'hB: begin t1 = ia & ib;    t2 = 15;         end
         4'hC: begin t1 = ia;         t2 = ia;         end
         4'hD: begin t1 = ia | ib;    t2 = ia;         end
         4'hE: begin t1 = ia | inb;   t2 = ia;         end
         default: begin t1 = ia;      t2 = 15;         end
      endcase
      nocin = t1 + t2;
      sum   = nocin + (ci_n ? 0 : 1);
      cout  = (sum >= 16);
      case (s)
         4'h0: lf = ~a;
         4'h1: lf = ~(a | b);
         4'h2: lf = ~a & b;
         4'h3: lf = 4'h0;
         4'h4: lf = ~(a & b);
         4'h5: lf = ~b;
         4'h6: lf = a ^ b;
         4'h7: lf = a & ~b;
         4'h8: lf = ~a | b;
         4'h9: lf = ~(a ^ b);
         4'hA: lf = b;
         4'hB: lf = a & b;
         4'hC: lf = 4'hF;
         4'hD: lf = a | ~b;
         4'hE: lf = a | b;
         default: lf = a;
      endcase
      y = m ? lf : 4'(sum % 16);
      for (int unsigned i = 0; i < 4; i++)
         gbit[i] = a[i] | (b[i] & s[0]) | (~b[i] & s[1]);
      p = ~(&gbit);
      q = ~(nocin >= 16);
      return {y, ~cout, p, q, (y == 4'hF)};
   endfunction

   task automatic issue(input logic rst, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] s, input logic m, input logic ci_n,
                        input string tag);
      @(negedge clk);
      reset          = rst;
      bus.a          = a;
      bus.b          = b;
      bus.s          = s;
      bus.M          = m;
      bus.Ci_inverse = ci_n;
      exp_q.push_back(rst ? RESET_EXP : model(a, b, s, m, ci_n));
      tag_q.push_back(tag);
   endtask

   task automatic issue_k(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] s, input logic m, input logic ci_n,
                          input logic [7:0] expv, input string tag);
      @(negedge clk);
      reset          = 1'b0;
      bus.a          = a;
      bus.b          = b;
      bus.s          = s;
      bus.M          = m;
      bus.Ci_inverse = ci_n;
      exp_q.push_back(expv);
      tag_q.push_back(tag);
   endtask

   // Monitor: every edge with a pending expectation is one comparison.
   initial begin
      logic [7:0] e, got;
      string      t;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            t   = tag_q.pop_front();
            got = {bus.Y, bus.Co_inverse, bus.P, bus.Q, bus.AequalsB};
            total++;
            if (got !== e) begin
               bad++;
               $display("FAIL %s: got Y=%h Co_n=%b P=%b Q=%b AeqB=%b, need Y=%h Co_n=%b P=%b Q=%b AeqB=%b",
                        t, got[7:4], got[3], got[2], got[1], got[0],
                        e[7:4], e[3], e[2], e[1], e[0]);
            end
         end
      end
   end

   initial begin
      logic [3:0] acc;
      logic [7:0] ev;
      reset = 1'b0;
      bus.a = '0; bus.b = '0; bus.s = '0; bus.M = 1'b0; bus.Ci_inverse = 1'b1;

      // reset with random inputs
      issue(1'b1, 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), "reset");

      // accumulate: b follows the registered Y
      acc = 4'h0;
      for (int unsigned i = 0; i < 16; i++) begin
         issue(1'b0, 4'h1, acc, 4'b1001, 1'b0, 1'b1, "accum");
         acc = acc + 4'h1;
      end

      // documented arithmetic examples
      issue_k(4'd9, 4'd9, 4'b0110, 1'b0, 1'b1, {4'hF, 1'b1, 1'b0, 1'b1, 1'b1}, "cmp_eq");
      issue_k(4'd9, 4'd9, 4'b0110, 1'b0, 1'b0, {4'h0, 1'b0, 1'b0, 1'b1, 1'b0}, "cmp_eq_cin");
      issue_k(4'd7, 4'd9, 4'b1001, 1'b0, 1'b1, {4'h0, 1'b0, 1'b0, 1'b0, 1'b0}, "add_carry");

      // logic sweep, with a few fixed results
      for (int unsigned s = 0; s < 16; s++)
         issue(1'b0, 4'b1100, 4'b1010, 4'(s), 1'b1, 1'($urandom), "logic_sweep");
      issue_k(4'b1100, 4'b1010, 4'b0110, 1'b1, 1'b1, {4'b0110, 1'b0, 1'b1, 1'b0, 1'b0}, "logic_xor");
      ev = model(4'b1100, 4'b1010, 4'b1011, 1'b1, 1'b1);
      ev[7:4] = 4'b1000;
      issue_k(4'b1100, 4'b1010, 4'b1011, 1'b1, 1'b1, ev, "logic_and");
      ev = model(4'b1100, 4'b1010, 4'b0011, 1'b1, 1'b0);
      ev[7:4] = 4'b0000;
      issue_k(4'b1100, 4'b1010, 4'b0011, 1'b1, 1'b0, ev, "logic_zero");

      // reset mid-operation discards the in-flight result
      issue(1'b0, 4'd5, 4'd3, 4'b1001, 1'b0, 1'b1, "pre_reset");
      issue(1'b1, 4'd5, 4'd3, 4'b1001, 1'b0, 1'b0, "mid_reset");
      issue(1'b0, 4'd5, 4'd3, 4'b1001, 1'b0, 1'b1, "post_reset");

      // reset pulse between edges is ignored
      @(negedge clk);
      bus.a = 4'd6; bus.b = 4'd2; bus.s = 4'b0110; bus.M = 1'b0; bus.Ci_inverse = 1'b1;
      reset = 1'b1;
      #2 reset = 1'b0;
      exp_q.push_back(model(4'd6, 4'd2, 4'b0110, 1'b0, 1'b1));
      tag_q.push_back("reset_glitch");

      // random vectors with occasional reset
      for (int unsigned i = 0; i < 2000; i++)
         issue(($urandom_range(0, 49) == 0), 4'($urandom), 4'($urandom), 4'($urandom),
               1'($urandom), 1'($urandom), "random");

      // exhaustive
      for (int unsigned v = 0; v < 4096 * 4; v++)
         issue(1'b0, 4'(v), 4'(v >> 4), 4'(v >> 8), 1'(v >> 12), 1'(v >> 13), "exhaustive");

      // drain with a bounded wait
      for (int unsigned i = 0; i < 10 && exp_q.size() > 0; i++)
         @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain: pending=%0d, need 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
